// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN result transmit path.
//   tx_state_t   : transmit FSM encoding (HDR used only when CNN_RESULT_TX_HDR_EN is defined)
//   HDR_BYTE     : frame header byte sent ahead of each frame in the header build
//   frame_bytes  : bytes needed to carry one w x h result frame, one bit per window
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    HDR
  } tx_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  function automatic int unsigned frame_bytes(input int unsigned w, input int unsigned h);
    return (w * h + 7) / 8;
  endfunction

endpackage

// File: rtl/cnn_tx_fifo.sv
// Synchronous FIFO used to buffer packed result bytes ahead of the UART.
// Ports:
//   clk, rst (async, active-high), clr (sync flush)
//   push/din   : write side; a push while full is dropped
//   pop/dout   : read side; dout shows the head entry combinationally
//   full/empty : occupancy flags
module cnn_tx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cnn_result_tx.sv
// Packs the CNN core's 1-bit-per-window result stream LSB-first into bytes,
// buffers them, and hands them to the UART transmitter one at a time.
// Build option: CNN_RESULT_TX_HDR_EN prefixes every frame with HDR_BYTE.
// Ports:
//   clk, rst (async, active-high), clr (sync flush of packer/counters/FIFO)
//   bit_vld/bit_in/bit_rdy : result-bit input handshake
//   trmt/tx_data/tx_done   : UART transmit handshake (trmt one-cycle pulse)
//   frame_done             : one-cycle pulse after the last byte of a frame completes
module cnn_result_tx
  import cnn_pkg::*;
#(
  parameter int unsigned MAP_W      = 26,
  parameter int unsigned MAP_H      = 26,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_vld,
  input  logic       bit_in,
  output logic       bit_rdy,
  output logic       trmt,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       frame_done
);

  localparam logic [9:0] LAST_IDX = 10'(MAP_W * MAP_H - 1);

  logic [7:0] pack;
  logic [2:0] cnt_8;
  logic [9:0] bit_cnt;
  logic       accept;
  logic       last_bit;
  logic       push;
  logic       pop;
  logic [7:0] byte_w;
  logic [8:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  tx_state_t  state;
  logic       last_q;
`ifdef CNN_RESULT_TX_HDR_EN
  logic       first_q;
`endif

  assign bit_rdy  = !rst && !fifo_full;
  assign accept   = bit_vld && bit_rdy && !clr;
  assign last_bit = (bit_cnt == LAST_IDX);
  assign push     = accept && ((cnt_8 == 3'd7) || last_bit);
  assign pop      = (state == LOAD);

  // Byte as it would stand with the current bit merged in; bits above the
  // current slot are forced to zero so a short final byte is zero-padded.
  always_comb begin
    byte_w         = pack;
    byte_w[cnt_8]  = bit_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i > {29'd0, cnt_8}) byte_w[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack    <= '0;
      cnt_8   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      pack    <= '0;
      cnt_8   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      if (push) begin
        pack  <= '0;
        cnt_8 <= '0;
      end else begin
        pack[cnt_8] <= bit_in;
        cnt_8       <= cnt_8 + 3'd1;
      end
      bit_cnt <= last_bit ? '0 : bit_cnt + 10'd1;
    end
  end

  cnn_tx_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   ({last_bit, byte_w}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx_data is captured on the IDLE exit so it is already valid while trmt is
  // high; the head entry cannot change before the LOAD-cycle pop, so this is
  // the same value a LOAD-time capture would hold through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trmt       <= 1'b0;
      tx_data    <= '0;
      frame_done <= 1'b0;
      last_q     <= 1'b0;
`ifdef CNN_RESULT_TX_HDR_EN
      first_q    <= 1'b1;
`endif
    end else begin
      trmt       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !clr) begin
            trmt <= 1'b1;
`ifdef CNN_RESULT_TX_HDR_EN
            if (first_q) begin
              state   <= HDR;
              tx_data <= HDR_BYTE;
            end else begin
              state   <= LOAD;
              tx_data <= fifo_dout[7:0];
            end
`else
            state   <= LOAD;
            tx_data <= fifo_dout[7:0];
`endif
          end
        end
        LOAD: begin
          last_q <= fifo_dout[8] && !clr;
          state  <= WAIT;
        end
`ifdef CNN_RESULT_TX_HDR_EN
        HDR: begin
          last_q  <= 1'b0;
          first_q <= 1'b0;
          state   <= WAIT;
        end
`endif
        WAIT: begin
          // A flushed frame must not report completion for its in-flight byte.
          if (clr) last_q <= 1'b0;
          if (tx_done) begin
            frame_done <= last_q && !clr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef CNN_RESULT_TX_HDR_EN
      if (clr || (state == WAIT && tx_done && last_q)) first_q <= 1'b1;
`endif
    end
  end

endmodule
